// File: rtl/regfile_write_port_if.sv
// Write-request handshake between a writeback producer and the register-bank
// write port: valid/ready plus destination index and data.
interface regfile_write_port_if #(
   parameter int WIDTH = 16
);
   logic             wr_valid;
   logic             wr_ready;
   logic [3:0]       wr_addr;
   logic [WIDTH-1:0] wr_data;

   modport master (
      output wr_valid,
      output wr_addr,
      output wr_data,
      input  wr_ready
   );

   modport slave (
      input  wr_valid,
      input  wr_addr,
      input  wr_data,
      output wr_ready
   );
endinterface

// File: rtl/regfile_write_port.sv
// Write side of the 16-entry register bank: posted-write FIFO drained one entry
// per cycle, plus a 16-cycle clear sequencer that takes priority over draining.
module regfile_write_port #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   regfile_write_port_if.slave wr_if,
   input  logic                clr_req,
   output logic                clr_busy,
   output logic [2:0]          wr_count,
   output logic                commit_valid,
   output logic [3:0]          commit_addr,
   output logic [WIDTH-1:0]    r0,
   output logic [WIDTH-1:0]    r1,
   output logic [WIDTH-1:0]    r2,
   output logic [WIDTH-1:0]    r3,
   output logic [WIDTH-1:0]    r4,
   output logic [WIDTH-1:0]    r5,
   output logic [WIDTH-1:0]    r6,
   output logic [WIDTH-1:0]    r7,
   output logic [WIDTH-1:0]    r8,
   output logic [WIDTH-1:0]    r9,
   output logic [WIDTH-1:0]    r10,
   output logic [WIDTH-1:0]    r11,
   output logic [WIDTH-1:0]    r12,
   output logic [WIDTH-1:0]    r13,
   output logic [WIDTH-1:0]    r14,
   output logic [WIDTH-1:0]    r15
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);

   typedef enum logic {IDLE, CLEAR} state_e;

   state_e           state_q, state_d;
   logic [3:0]       clr_idx_q, clr_idx_d;
   logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]    count_q, count_d;
   logic             commit_valid_q;
   logic [3:0]       commit_addr_q;

   logic [3:0]       fifo_addr_q [DEPTH];
   logic [WIDTH-1:0] fifo_data_q [DEPTH];

   logic             full, empty, push, pop, clr_we;
   logic [3:0]       head_addr;
   logic [WIDTH-1:0] head_data;
   logic [15:0]      bank_we;
   logic [WIDTH-1:0] bank_wdata;
   logic [WIDTH-1:0] bank [16];

   assign full          = (count_q == CW'(DEPTH));
   assign empty         = (count_q == '0);
   assign wr_if.wr_ready = !full;
   assign push          = wr_if.wr_valid && !full;
   assign head_addr     = fifo_addr_q[rd_ptr_q];
   assign head_data     = fifo_data_q[rd_ptr_q];

   // Queue storage carries no reset; only the pointers and count define validity.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_addr_q[wr_ptr_q] <= wr_if.wr_addr;
         fifo_data_q[wr_ptr_q] <= wr_if.wr_data;
      end
   end

   always_comb begin
      count_d = count_q;
      case ({push, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q       <= '0;
         rd_ptr_q       <= '0;
         count_q        <= '0;
         state_q        <= IDLE;
         clr_idx_q      <= '0;
         commit_valid_q <= 1'b0;
         commit_addr_q  <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
         count_q        <= count_d;
         state_q        <= state_d;
         clr_idx_q      <= clr_idx_d;
         commit_valid_q <= pop;
         if (pop) commit_addr_q <= head_addr;
      end
   end

   // A clear request in IDLE wins over a pending drain for that cycle.
   always_comb begin
      state_d   = state_q;
      clr_idx_d = clr_idx_q;
      pop       = 1'b0;
      clr_we    = 1'b0;
      case (state_q)
         IDLE: begin
            if (clr_req) begin
               state_d   = CLEAR;
               clr_idx_d = '0;
            end else if (!empty) begin
               pop = 1'b1;
            end
         end
         CLEAR: begin
            clr_we    = 1'b1;
            clr_idx_d = clr_idx_q + 4'd1;
            if (clr_idx_q == 4'd15) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign bank_wdata = pop ? head_data : '0;

   generate
      for (genvar gi = 0; gi < 16; gi++) begin : g_bank
         logic [WIDTH-1:0] reg_q;

         assign bank_we[gi] = (pop && (head_addr == 4'(gi))) ||
                              (clr_we && (clr_idx_q == 4'(gi)));

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)           reg_q <= '0;
            else if (bank_we[gi]) reg_q <= bank_wdata;
         end

         assign bank[gi] = reg_q;
      end
   endgenerate

   assign clr_busy     = (state_q == CLEAR);
   assign wr_count     = 3'(count_q);
   assign commit_valid = commit_valid_q;
   assign commit_addr  = commit_addr_q;

   assign r0  = bank[0];
   assign r1  = bank[1];
   assign r2  = bank[2];
   assign r3  = bank[3];
   assign r4  = bank[4];
   assign r5  = bank[5];
   assign r6  = bank[6];
   assign r7  = bank[7];
   assign r8  = bank[8];
   assign r9  = bank[9];
   assign r10 = bank[10];
   assign r11 = bank[11];
   assign r12 = bank[12];
   assign r13 = bank[13];
   assign r14 = bank[14];
   assign r15 = bank[15];
endmodule

// File: tb/tb_regfile_write_port.sv
// Self-checking bench for regfile_write_port: directed vector table, hand-written
// corner sequences and random traffic against a queue-based reference model.
module tb_regfile_write_port;
   localparam int WIDTH = 16;
   localparam int DEPTH = 4;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             clr_req = 1'b0;
   logic             clr_busy;
   logic [2:0]       wr_count;
   logic             commit_valid;
   logic [3:0]       commit_addr;
   logic [WIDTH-1:0] rv [16];

   regfile_write_port_if #(.WIDTH(WIDTH)) wr_bus ();

   regfile_write_port #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n), .wr_if(wr_bus),
      .clr_req(clr_req), .clr_busy(clr_busy), .wr_count(wr_count),
      .commit_valid(commit_valid), .commit_addr(commit_addr),
      .r0(rv[0]), .r1(rv[1]), .r2(rv[2]), .r3(rv[3]),
      .r4(rv[4]), .r5(rv[5]), .r6(rv[6]), .r7(rv[7]),
      .r8(rv[8]), .r9(rv[9]), .r10(rv[10]), .r11(rv[11]),
      .r12(rv[12]), .r13(rv[13]), .r14(rv[14]), .r15(rv[15])
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference model: pending writes as a queue, clear progress as an index.
   typedef struct packed {
      logic [3:0]       addr;
      logic [WIDTH-1:0] data;
   } entry_t;

   entry_t           m_q [$];
   int               m_clr = -1;
   logic [WIDTH-1:0] m_regs [16];
   logic             m_cv;
   logic [3:0]       m_ca;

   typedef struct {
      int               reps;
      logic             v;
      logic [3:0]       a;
      logic [WIDTH-1:0] d;
      logic             clr;
      int               cnt;
      logic             rdy;
      logic             busy;
      logic             cv;
      logic [3:0]       ca;
      logic             rchk;
      logic [3:0]       ridx;
      logic [WIDTH-1:0] rval;
   } vec_t;

   vec_t vecs [$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_q.delete();
      m_clr = -1;
      for (int i = 0; i < 16; i++) m_regs[i] = '0;
      m_cv = 1'b0;
      m_ca = '0;
   endtask

   task automatic model_step();
      bit     can_push;
      entry_t e;
      can_push = (m_q.size() < DEPTH);
      m_cv = 1'b0;
      if (m_clr >= 0) begin
         m_regs[m_clr] = '0;
         m_clr = (m_clr == 15) ? -1 : m_clr + 1;
      end else if (clr_req) begin
         m_clr = 0;
         $display("clear start");
      end else if (m_q.size() > 0) begin
         e = m_q.pop_front();
         m_regs[e.addr] = e.data;
         m_cv = 1'b1;
         m_ca = e.addr;
         $display("commit r%0d <= %04h", e.addr, e.data);
      end
      if (wr_bus.wr_valid && can_push) begin
         e.addr = wr_bus.wr_addr;
         e.data = wr_bus.wr_data;
         m_q.push_back(e);
      end
   endtask

   task automatic check_all();
      chk("wr_count", 32'(wr_count), 32'(m_q.size()));
      chk("wr_ready", 32'(wr_bus.wr_ready), 32'(m_q.size() < DEPTH));
      chk("clr_busy", 32'(clr_busy), 32'(m_clr >= 0));
      chk("commit_valid", 32'(commit_valid), 32'(m_cv));
      chk("commit_addr", 32'(commit_addr), 32'(m_ca));
      for (int i = 0; i < 16; i++) chk($sformatf("r%0d", i), 32'(rv[i]), 32'(m_regs[i]));
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
      check_all();
   endtask

   task automatic drive(input logic v, input logic [3:0] a, input logic [WIDTH-1:0] d, input logic c);
      wr_bus.wr_valid = v;
      wr_bus.wr_addr  = a;
      wr_bus.wr_data  = d;
      clr_req         = c;
   endtask

   task automatic check_reset_values(input string tag);
      chk({tag, "_count"}, 32'(wr_count), 32'd0);
      chk({tag, "_ready"}, 32'(wr_bus.wr_ready), 32'd1);
      chk({tag, "_busy"}, 32'(clr_busy), 32'd0);
      chk({tag, "_cv"}, 32'(commit_valid), 32'd0);
      chk({tag, "_ca"}, 32'(commit_addr), 32'd0);
      for (int i = 0; i < 16; i++) chk($sformatf("%s_r%0d", tag, i), 32'(rv[i]), 32'd0);
   endtask

   initial begin
      int busy_cycles;
      int commits;

      drive(1'b0, 4'd0, '0, 1'b0);
      model_reset();

      // Reset state
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_reset_values("rst");
      rst_n = 1'b1;
      tick();

      // Single write latency, then a clear with pushes filling the FIFO during it.
      vecs.push_back('{1, 1'b1, 4'd5, 16'hBEEF, 1'b0, 1, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 16'h0});
      vecs.push_back('{1, 1'b0, 4'd0, 16'h0000, 1'b0, 0, 1'b1, 1'b0, 1'b1, 4'd5, 1'b1, 4'd5, 16'hBEEF});
      vecs.push_back('{1, 1'b0, 4'd0, 16'h0000, 1'b1, 0, 1'b1, 1'b1, 1'b0, 4'd5, 1'b0, 4'd0, 16'h0});
      vecs.push_back('{1, 1'b1, 4'd1, 16'h0011, 1'b0, 1, 1'b1, 1'b1, 1'b0, 4'd5, 1'b0, 4'd0, 16'h0});
      vecs.push_back('{1, 1'b1, 4'd2, 16'h0022, 1'b0, 2, 1'b1, 1'b1, 1'b0, 4'd5, 1'b0, 4'd0, 16'h0});
      vecs.push_back('{1, 1'b1, 4'd3, 16'h0033, 1'b0, 3, 1'b1, 1'b1, 1'b0, 4'd5, 1'b0, 4'd0, 16'h0});
      vecs.push_back('{1, 1'b1, 4'd4, 16'h0044, 1'b0, 4, 1'b0, 1'b1, 1'b0, 4'd5, 1'b0, 4'd0, 16'h0});
      vecs.push_back('{1, 1'b1, 4'd5, 16'h0055, 1'b0, 4, 1'b0, 1'b1, 1'b0, 4'd5, 1'b0, 4'd0, 16'h0});
      vecs.push_back('{10, 1'b0, 4'd0, 16'h0000, 1'b0, 4, 1'b0, 1'b1, 1'b0, 4'd5, 1'b1, 4'd5, 16'h0});
      vecs.push_back('{1, 1'b0, 4'd0, 16'h0000, 1'b0, 4, 1'b0, 1'b0, 1'b0, 4'd5, 1'b1, 4'd15, 16'h0});
      vecs.push_back('{1, 1'b0, 4'd0, 16'h0000, 1'b0, 3, 1'b1, 1'b0, 1'b1, 4'd1, 1'b1, 4'd1, 16'h0011});
      vecs.push_back('{1, 1'b0, 4'd0, 16'h0000, 1'b0, 2, 1'b1, 1'b0, 1'b1, 4'd2, 1'b1, 4'd2, 16'h0022});
      vecs.push_back('{1, 1'b0, 4'd0, 16'h0000, 1'b0, 1, 1'b1, 1'b0, 1'b1, 4'd3, 1'b1, 4'd3, 16'h0033});
      vecs.push_back('{1, 1'b0, 4'd0, 16'h0000, 1'b0, 0, 1'b1, 1'b0, 1'b1, 4'd4, 1'b1, 4'd4, 16'h0044});

      foreach (vecs[i]) begin
         for (int r = 0; r < vecs[i].reps; r++) begin
            drive(vecs[i].v, vecs[i].a, vecs[i].d, vecs[i].clr);
            tick();
            chk($sformatf("vec%0d_count", i), 32'(wr_count), 32'(vecs[i].cnt));
            chk($sformatf("vec%0d_ready", i), 32'(wr_bus.wr_ready), 32'(vecs[i].rdy));
            chk($sformatf("vec%0d_busy", i), 32'(clr_busy), 32'(vecs[i].busy));
            chk($sformatf("vec%0d_cv", i), 32'(commit_valid), 32'(vecs[i].cv));
            chk($sformatf("vec%0d_ca", i), 32'(commit_addr), 32'(vecs[i].ca));
            if (vecs[i].rchk)
               chk($sformatf("vec%0d_r%0d", i, vecs[i].ridx), 32'(rv[vecs[i].ridx]), 32'(vecs[i].rval));
         end
      end
      drive(1'b0, 4'd0, '0, 1'b0);

      // Random traffic against the reference model
      for (int i = 0; i < 300; i++) begin
         drive(1'($urandom_range(0, 9) < 6), 4'($urandom_range(0, 15)),
               WIDTH'($urandom), 1'($urandom_range(0, 39) == 0));
         tick();
      end
      drive(1'b0, 4'd0, '0, 1'b0);
      repeat (25) tick();

      // Clear priority over drain; the entry queued with the request survives.
      drive(1'b1, 4'd3, 16'h1234, 1'b0);
      tick();
      drive(1'b0, 4'd0, '0, 1'b0);
      tick();
      chk("pre_clear_r3", 32'(rv[3]), 32'h1234);
      drive(1'b1, 4'd3, 16'hAAAA, 1'b1);
      tick();
      busy_cycles = int'(clr_busy);
      drive(1'b0, 4'd0, '0, 1'b0);
      for (int i = 0; i < 20; i++) begin
         tick();
         busy_cycles += int'(clr_busy);
      end
      chk("clear_length", 32'(busy_cycles), 32'd16);
      chk("post_clear_r3", 32'(rv[3]), 32'hAAAA);

      // Back-to-back pushes to one register: pointer wrap, last write wins.
      commits = 0;
      for (int k = 1; k <= 10; k++) begin
         drive(1'b1, 4'd7, WIDTH'(k), 1'b0);
         tick();
         chk("stream_count_le1", 32'(wr_count <= 3'd1), 32'd1);
         commits += int'(commit_valid);
      end
      drive(1'b0, 4'd0, '0, 1'b0);
      tick();
      commits += int'(commit_valid);
      chk("stream_commits", 32'(commits), 32'd10);
      chk("stream_r7", 32'(rv[7]), 32'd10);

      // Reset asserted on clear cycle 8 with two entries queued.
      drive(1'b0, 4'd0, '0, 1'b1);
      tick();
      drive(1'b1, 4'd9, 16'h0001, 1'b0);
      tick();
      drive(1'b1, 4'd10, 16'h0002, 1'b0);
      tick();
      drive(1'b0, 4'd0, '0, 1'b0);
      repeat (5) tick();
      chk("pre_reset_count", 32'(wr_count), 32'd2);
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      check_reset_values("midclr");
      @(posedge clk);
      #1;
      check_reset_values("midclr_hold");
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         tick();
         chk("no_stale_commit", 32'(commit_valid), 32'd0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
